coin_credit_manager: RTL and testbench
======================================

# coin_credit_manager

Upstream stage of the purchase path. Accepts coin insertions and tracks the customer's running credit as an 8-bit value in cents. That credit drives the `credit[7:0]` input of the purchase manager. It deducts the price when the purchase manager reports a vend, and pays out change one coin per cycle on a refund request.

## Interface
- `MAX_CREDIT`, default 200: highest credit (cents) the block holds; must be ≤ 255.
- `clk`  input  1  system clock; all state changes on its rising edge.
- `reset`  input  1  asynchronous, active-low; asserted at 0.
- `coin_valid`  input  1  single-cycle strobe: one coin inserted.
- `coin_type`  input  2  coin value, sampled with `coin_valid`: 00 = 5, 01 = 10, 10 = 25, 11 = 100.
- `vend_done`  input  1  single-cycle strobe from the purchase manager: an item was dispensed.
- `vend_price`  input  8  price of the dispensed item, sampled with `vend_done`.
- `refund_req`  input  1  single-cycle strobe: return all credit.
- `credit`  output  8  current credit in cents; registered.
- `coin_reject`  output  1  one-cycle pulse: the coin was returned and not counted.
- `underflow`  output  1  one-cycle pulse: `vend_price` exceeded credit.
- `change_valid`  output  1  one-cycle pulse per change coin ejected.
- `change_type`  output  2  value of the ejected coin, same encoding as `coin_type`; 00 when idle.
- `busy`  output  1  high while in state REFUND.

## Operation
- **Reset values.** State IDLE. `credit`=0. All pulse outputs 0. `change_type`=00. `busy`=0.
- **States.** IDLE (the only state that accepts input) and REFUND (change payout).
- **IDLE priority per cycle:** vend > refund > coin.
  - `vend_done`, price ≤ credit: credit ← credit − price.
  - `vend_done`, price > credit: credit unchanged, `underflow` pulse.
  - `refund_req` in the same cycle as `vend_done`: the deduction is applied first, then the block enters REFUND with the reduced credit.
  - `refund_req` alone: enter REFUND if credit ≥ 5. Otherwise credit ← 0 and stay in IDLE.
  - `coin_valid` with no vend or refund that cycle:
    - credit + value ≤ `MAX_CREDIT`: credit ← credit + value.
    - credit + value > `MAX_CREDIT`: `coin_reject` pulse, credit unchanged.
  - `coin_valid` coinciding with `vend_done` or `refund_req`: `coin_reject` pulse, coin not counted.
- **Arithmetic.** The sum is computed 9 bits wide, so it never wraps.
- **REFUND, each cycle,** eject one coin by greedy selection on the current credit:
  - ≥ 25: quarter.
  - ≥ 10: dime.
  - ≥ 5: nickel.
  - Assert `change_valid` and `change_type`, and subtract the coin value from credit.
  - Dollars are never paid out as change.
  - When the credit after subtraction is < 5: credit ← 0 (residue forfeited) and return to IDLE.
- **Inputs during REFUND:**
  - `coin_valid` produces a `coin_reject` pulse.
  - `vend_done` and `refund_req` are ignored.

## Timing
- Coin accept, vend deduct and reject/underflow pulses are visible on the cycle after the strobe is sampled (1-cycle latency).
- The first change coin appears the cycle after REFUND is entered.
- A refund of N cents takes the greedy coin count in cycles. Example: 40 = Q, D, N over 3 consecutive cycles.
- `busy` rises the cycle after `refund_req` and falls in the cycle credit reaches 0.
- Reset asserted mid-refund aborts the payout immediately: credit 0, IDLE. Coins not yet paid are lost.
- `credit` changes only on clock edges and is stable for the purchase manager for a full cycle.

## Configuration
- **`AUTO_CHANGE_EN` defined:** a successful `vend_done` whose remaining credit is ≥ 5 enters REFUND automatically on the next cycle, paying out the remaining credit.
- **`AUTO_CHANGE_EN` undefined:** remaining credit is retained for further purchases. Payout happens only on `refund_req`.

## Structure
- Package `coin_pkg` holds:
  - the coin encodings (`COIN_NICKEL`, `COIN_DIME`, `COIN_QUARTER`, `COIN_DOLLAR`);
  - their cent values;
  - the state enum (IDLE, REFUND).
- Sub-module `change_selector` is purely combinational. It takes the 8-bit credit and outputs the greedy coin type, the coin value, and a `none` flag (credit < 5).
- The top module holds the state register, the credit register and the priority logic.

## Test plan
- **Coin accumulation:** after reset, insert 25, 25, 100 → credit 25, 50, 150 on successive cycles, no reject.
- **Saturation:** credit 150, insert 100 → `coin_reject` pulse, credit stays 150. Then insert 25 → credit 175.
- **Vend deduction:** credit 175, `vend_done` with price 75 → credit 100. Then price 120 → `underflow`, credit 100.
- **Refund payout:** credit 40, `refund_req` → `change_type` Q, D, N on 3 consecutive cycles, `busy` high for 3 cycles, credit 0. A coin inserted mid-refund is rejected.
- **Simultaneous events:** credit 60, `vend_done` price 35 with `refund_req` and `coin_valid` all in one cycle → credit 25, coin rejected, then one quarter out.
- **Reset mid-refund:** credit 100, `refund_req`, reset after the first quarter → credit 0, `busy` 0, no further `change_valid`. With `AUTO_CHANGE_EN`: credit 50, vend 35 → one dime and one nickel out automatically.

Source files
------------

// File: rtl/coin_pkg.sv
// Shared encodings, cent values and state type for the coin credit path.
package coin_pkg;

  localparam int unsigned CREDIT_W = 8;
  localparam int unsigned SUM_W    = 9;
  localparam int unsigned COIN_W   = 2;

  localparam logic [COIN_W-1:0] COIN_NICKEL  = 2'b00;
  localparam logic [COIN_W-1:0] COIN_DIME    = 2'b01;
  localparam logic [COIN_W-1:0] COIN_QUARTER = 2'b10;
  localparam logic [COIN_W-1:0] COIN_DOLLAR  = 2'b11;

  localparam logic [CREDIT_W-1:0] NICKEL_CENTS  = 8'd5;
  localparam logic [CREDIT_W-1:0] DIME_CENTS    = 8'd10;
  localparam logic [CREDIT_W-1:0] QUARTER_CENTS = 8'd25;
  localparam logic [CREDIT_W-1:0] DOLLAR_CENTS  = 8'd100;

  typedef enum logic {
    IDLE   = 1'b0,
    REFUND = 1'b1
  } state_e;

  // Cent value of an inserted coin encoding.
  function automatic logic [CREDIT_W-1:0] coin_cents(input logic [COIN_W-1:0] coin);
    logic [CREDIT_W-1:0] cents;
    case (coin)
      COIN_NICKEL:  cents = NICKEL_CENTS;
      COIN_DIME:    cents = DIME_CENTS;
      COIN_QUARTER: cents = QUARTER_CENTS;
      default:      cents = DOLLAR_CENTS;
    endcase
    return cents;
  endfunction

endpackage

// File: rtl/coin_credit_manager_if.sv
// Coin/vend/refund strobes in, credit and change payout out.
interface coin_credit_manager_if;
  import coin_pkg::*;

  logic                  coin_valid;
  logic [COIN_W-1:0]     coin_type;
  logic                  vend_done;
  logic [CREDIT_W-1:0]   vend_price;
  logic                  refund_req;
  logic [CREDIT_W-1:0]   credit;
  logic                  coin_reject;
  logic                  underflow;
  logic                  change_valid;
  logic [COIN_W-1:0]     change_type;
  logic                  busy;

  modport master (
    output coin_valid, coin_type, vend_done, vend_price, refund_req,
    input  credit, coin_reject, underflow, change_valid, change_type, busy
  );

  modport slave (
    input  coin_valid, coin_type, vend_done, vend_price, refund_req,
    output credit, coin_reject, underflow, change_valid, change_type, busy
  );

endinterface

// File: rtl/change_selector.sv
// Greedy change coin choice (quarter, dime, nickel) for a given credit; never dollars.
module change_selector
  import coin_pkg::*;
(
  input  logic [CREDIT_W-1:0] credit,
  output logic [COIN_W-1:0]   coin,
  output logic [CREDIT_W-1:0] value,
  output logic                none
);

  always_comb begin
    coin  = COIN_NICKEL;
    value = NICKEL_CENTS;
    none  = 1'b0;
    if (credit >= QUARTER_CENTS) begin
      coin  = COIN_QUARTER;
      value = QUARTER_CENTS;
    end else if (credit >= DIME_CENTS) begin
      coin  = COIN_DIME;
      value = DIME_CENTS;
    end else if (credit < NICKEL_CENTS) begin
      value = '0;
      none  = 1'b1;
    end
  end

endmodule

// File: rtl/coin_credit_manager.sv
// Running coin credit with vend deduction and one-coin-per-cycle refund payout.
// Define AUTO_CHANGE_EN to pay out remaining credit automatically after each vend.
module coin_credit_manager
  import coin_pkg::*;
#(
  parameter int unsigned MAX_CREDIT = 200
) (
  input  logic                  clk,
  input  logic                  reset,
  coin_credit_manager_if.slave  bus
);

  localparam logic [SUM_W-1:0] MAX_SUM = SUM_W'(MAX_CREDIT);

  state_e                state_q, state_n;
  logic [CREDIT_W-1:0]   credit_q, credit_n;
  logic                  reject_q, reject_n;
  logic                  underflow_q, underflow_n;
  logic                  change_valid_q, change_valid_n;
  logic [COIN_W-1:0]     change_type_q, change_type_n;
  logic                  busy_q, busy_n;

  logic [COIN_W-1:0]     sel_coin;
  logic [CREDIT_W-1:0]   sel_value;
  logic                  sel_none;

  logic                  vend_ok;
  logic [CREDIT_W-1:0]   after_vend;
  logic [SUM_W-1:0]      coin_sum;
  logic [CREDIT_W-1:0]   remaining;

  change_selector u_change_selector (
    .credit (credit_q),
    .coin   (sel_coin),
    .value  (sel_value),
    .none   (sel_none)
  );

  // Vend result and coin sum are evaluated every cycle; the FSM picks which applies.
  assign vend_ok    = (bus.vend_price <= credit_q);
  assign after_vend = vend_ok ? (credit_q - bus.vend_price) : credit_q;
  assign coin_sum   = SUM_W'(credit_q) + SUM_W'(coin_cents(bus.coin_type));
  assign remaining  = credit_q - sel_value;

  always_comb begin
    state_n        = state_q;
    credit_n       = credit_q;
    reject_n       = 1'b0;
    underflow_n    = 1'b0;
    change_valid_n = 1'b0;
    change_type_n  = COIN_NICKEL;

    case (state_q)
      IDLE: begin
        if (bus.vend_done) begin
          credit_n    = after_vend;
          underflow_n = ~vend_ok;
          reject_n    = bus.coin_valid;
`ifdef AUTO_CHANGE_EN
          if (vend_ok && (after_vend >= NICKEL_CENTS)) begin
            state_n = REFUND;
          end
`endif
          if (bus.refund_req) begin
            if (after_vend >= NICKEL_CENTS) begin
              state_n = REFUND;
            end else begin
              credit_n = '0;
            end
          end
        end else if (bus.refund_req) begin
          reject_n = bus.coin_valid;
          if (credit_q >= NICKEL_CENTS) begin
            state_n = REFUND;
          end else begin
            credit_n = '0;
          end
        end else if (bus.coin_valid) begin
          if (coin_sum <= MAX_SUM) begin
            credit_n = coin_sum[CREDIT_W-1:0];
          end else begin
            reject_n = 1'b1;
          end
        end
      end

      REFUND: begin
        // Only coin insertions get a response while paying out.
        reject_n = bus.coin_valid;
        if (sel_none) begin
          credit_n = '0;
          state_n  = IDLE;
        end else begin
          change_valid_n = 1'b1;
          change_type_n  = sel_coin;
          if (remaining < NICKEL_CENTS) begin
            credit_n = '0;
            state_n  = IDLE;
          end else begin
            credit_n = remaining;
          end
        end
      end
    endcase

    busy_n = (state_n == REFUND);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      credit_q       <= '0;
      reject_q       <= 1'b0;
      underflow_q    <= 1'b0;
      change_valid_q <= 1'b0;
      change_type_q  <= COIN_NICKEL;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_n;
      credit_q       <= credit_n;
      reject_q       <= reject_n;
      underflow_q    <= underflow_n;
      change_valid_q <= change_valid_n;
      change_type_q  <= change_type_n;
      busy_q         <= busy_n;
    end
  end

  assign bus.credit       = credit_q;
  assign bus.coin_reject  = reject_q;
  assign bus.underflow    = underflow_q;
  assign bus.change_valid = change_valid_q;
  assign bus.change_type  = change_type_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_coin_credit_manager.sv
// Bench for coin_credit_manager: directed vector table, random traffic vs. a cents-level model, reset mid-payout.
module tb_coin_credit_manager;
  import coin_pkg::*;

  localparam int MAX_CREDIT = 200;

  logic clk;
  logic reset;
  coin_credit_manager_if bus();

  coin_credit_manager #(.MAX_CREDIT(MAX_CREDIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: credit in cents plus a queue of change coins still owed.
  int m_credit;
  int m_owed[$];
  int e_credit, e_rej, e_uf, e_cv, e_ct, e_busy;

  typedef struct {
    logic       cv;
    logic [1:0] ct;
    logic       vd;
    logic [7:0] vp;
    logic       rr;
    int credit; int rej; int uf; int chv; int cht; int busy;
  } vec_t;

  vec_t vecs[$];

  function automatic int cents(input int t);
    case (t)
      0: return 5;
      1: return 10;
      2: return 25;
      default: return 100;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input int credit, input int rej, input int uf,
                         input int chv, input int cht, input int busy);
    chk({tag, " credit"},       int'(bus.credit),       credit);
    chk({tag, " coin_reject"},  int'(bus.coin_reject),  rej);
    chk({tag, " underflow"},    int'(bus.underflow),    uf);
    chk({tag, " change_valid"}, int'(bus.change_valid), chv);
    chk({tag, " change_type"},  int'(bus.change_type),  cht);
    chk({tag, " busy"},         int'(bus.busy),         busy);
  endtask

  task automatic start_payout();
    int c;
    c = m_credit;
    while (c >= 25) begin m_owed.push_back(2); c -= 25; end
    while (c >= 10) begin m_owed.push_back(1); c -= 10; end
    while (c >= 5)  begin m_owed.push_back(0); c -= 5;  end
  endtask

  task automatic model_step(input int cv, input int ct, input int vd, input int vp, input int rr);
    bit start;
    int t;
    start = 0;
    e_rej = 0; e_uf = 0; e_cv = 0; e_ct = 0;
    if (m_owed.size() > 0) begin
      e_rej = cv;
      t = m_owed.pop_front();
      e_cv = 1;
      e_ct = t;
      m_credit -= cents(t);
      if (m_owed.size() == 0) m_credit = 0;
    end else begin
      if (vd != 0) begin
        e_rej = cv;
        if (vp <= m_credit) begin
          m_credit -= vp;
`ifdef AUTO_CHANGE_EN
          if (m_credit >= 5) start = 1;
`endif
        end else begin
          e_uf = 1;
        end
        if (rr != 0) begin
          if (m_credit >= 5) start = 1; else m_credit = 0;
        end
      end else if (rr != 0) begin
        e_rej = cv;
        if (m_credit >= 5) start = 1; else m_credit = 0;
      end else if (cv != 0) begin
        if (m_credit + cents(ct) <= MAX_CREDIT) m_credit += cents(ct);
        else e_rej = 1;
      end
      if (start) start_payout();
    end
    e_credit = m_credit;
    e_busy   = (m_owed.size() > 0) ? 1 : 0;
  endtask

  task automatic step(input logic cv, input logic [1:0] ct, input logic vd,
                      input logic [7:0] vp, input logic rr);
    bus.coin_valid = cv;
    bus.coin_type  = ct;
    bus.vend_done  = vd;
    bus.vend_price = vp;
    bus.refund_req = rr;
    @(posedge clk);
    #1;
    model_step(int'(cv), int'(ct), int'(vd), int'(vp), int'(rr));
    bus.coin_valid = 1'b0;
    bus.vend_done  = 1'b0;
    bus.refund_req = 1'b0;
  endtask

  task automatic idle_step();
    step(1'b0, 2'b00, 1'b0, 8'd0, 1'b0);
  endtask

  task automatic chk_model(input string tag);
    chk_all(tag, e_credit, e_rej, e_uf, e_cv, e_ct, e_busy);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    bus.coin_valid = 1'b0;
    bus.coin_type  = 2'b00;
    bus.vend_done  = 1'b0;
    bus.vend_price = 8'd0;
    bus.refund_req = 1'b0;
    #3;
    m_credit = 0;
    m_owed.delete();
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    #2;
    apply_reset();

`ifdef AUTO_CHANGE_EN
    vecs.push_back('{1'b1, 2'b10, 1'b0, 8'd0,  1'b0,  25, 0, 0, 0, 0, 0});
    vecs.push_back('{1'b1, 2'b10, 1'b0, 8'd0,  1'b0,  50, 0, 0, 0, 0, 0});
    vecs.push_back('{1'b0, 2'b00, 1'b1, 8'd35, 1'b0,  15, 0, 0, 0, 0, 1});
    vecs.push_back('{1'b0, 2'b00, 1'b0, 8'd0,  1'b0,   5, 0, 0, 1, 1, 1});
    vecs.push_back('{1'b0, 2'b00, 1'b0, 8'd0,  1'b0,   0, 0, 0, 1, 0, 0});
    vecs.push_back('{1'b1, 2'b01, 1'b0, 8'd0,  1'b0,  10, 0, 0, 0, 0, 0});
    vecs.push_back('{1'b0, 2'b00, 1'b1, 8'd10, 1'b0,   0, 0, 0, 0, 0, 0});
    vecs.push_back('{1'b0, 2'b00, 1'b1, 8'd1,  1'b0,   0, 0, 1, 0, 0, 0});
`else
    vecs.push_back('{1'b1, 2'b10, 1'b0, 8'd0,   1'b0,  25, 0, 0, 0, 0, 0});
    vecs.push_back('{1'b1, 2'b10, 1'b0, 8'd0,   1'b0,  50, 0, 0, 0, 0, 0});
    vecs.push_back('{1'b1, 2'b11, 1'b0, 8'd0,   1'b0, 150, 0, 0, 0, 0, 0});
    vecs.push_back('{1'b1, 2'b11, 1'b0, 8'd0,   1'b0, 150, 1, 0, 0, 0, 0});
    vecs.push_back('{1'b1, 2'b10, 1'b0, 8'd0,   1'b0, 175, 0, 0, 0, 0, 0});
    vecs.push_back('{1'b0, 2'b00, 1'b1, 8'd75,  1'b0, 100, 0, 0, 0, 0, 0});
    vecs.push_back('{1'b0, 2'b00, 1'b1, 8'd120, 1'b0, 100, 0, 1, 0, 0, 0});
    vecs.push_back('{1'b0, 2'b00, 1'b1, 8'd60,  1'b0,  40, 0, 0, 0, 0, 0});
    vecs.push_back('{1'b0, 2'b00, 1'b0, 8'd0,   1'b1,  40, 0, 0, 0, 0, 1});
    vecs.push_back('{1'b1, 2'b10, 1'b0, 8'd0,   1'b0,  15, 1, 0, 1, 2, 1});
    vecs.push_back('{1'b0, 2'b00, 1'b0, 8'd0,   1'b0,   5, 0, 0, 1, 1, 1});
    vecs.push_back('{1'b0, 2'b00, 1'b0, 8'd0,   1'b0,   0, 0, 0, 1, 0, 0});
    vecs.push_back('{1'b1, 2'b10, 1'b0, 8'd0,   1'b0,  25, 0, 0, 0, 0, 0});
    vecs.push_back('{1'b1, 2'b10, 1'b0, 8'd0,   1'b0,  50, 0, 0, 0, 0, 0});
    vecs.push_back('{1'b1, 2'b01, 1'b0, 8'd0,   1'b0,  60, 0, 0, 0, 0, 0});
    vecs.push_back('{1'b1, 2'b00, 1'b1, 8'd35,  1'b1,  25, 1, 0, 0, 0, 1});
    vecs.push_back('{1'b0, 2'b00, 1'b0, 8'd0,   1'b0,   0, 0, 0, 1, 2, 0});
    vecs.push_back('{1'b1, 2'b00, 1'b0, 8'd0,   1'b0,   5, 0, 0, 0, 0, 0});
    vecs.push_back('{1'b0, 2'b00, 1'b1, 8'd2,   1'b0,   3, 0, 0, 0, 0, 0});
    vecs.push_back('{1'b0, 2'b00, 1'b0, 8'd0,   1'b1,   0, 0, 0, 0, 0, 0});
    vecs.push_back('{1'b1, 2'b00, 1'b0, 8'd0,   1'b0,   5, 0, 0, 0, 0, 0});
    vecs.push_back('{1'b0, 2'b00, 1'b0, 8'd0,   1'b1,   5, 0, 0, 0, 0, 1});
    vecs.push_back('{1'b0, 2'b00, 1'b0, 8'd0,   1'b0,   0, 0, 0, 1, 0, 0});
    vecs.push_back('{1'b1, 2'b11, 1'b0, 8'd0,   1'b0, 100, 0, 0, 0, 0, 0});
    vecs.push_back('{1'b1, 2'b11, 1'b0, 8'd0,   1'b0, 200, 0, 0, 0, 0, 0});
    vecs.push_back('{1'b1, 2'b00, 1'b0, 8'd0,   1'b0, 200, 1, 0, 0, 0, 0});
    vecs.push_back('{1'b0, 2'b00, 1'b1, 8'd200, 1'b0,   0, 0, 0, 0, 0, 0});
`endif

    foreach (vecs[i]) begin
      step(vecs[i].cv, vecs[i].ct, vecs[i].vd, vecs[i].vp, vecs[i].rr);
      chk_all($sformatf("vec%0d", i), vecs[i].credit, vecs[i].rej, vecs[i].uf,
              vecs[i].chv, vecs[i].cht, vecs[i].busy);
    end

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic       cv, vd, rr;
      logic [1:0] ct;
      logic [7:0] vp;
      cv = ($urandom_range(0, 99) < 45);
      ct = 2'($urandom_range(0, 3));
      vd = ($urandom_range(0, 99) < 15);
      vp = 8'($urandom_range(0, 130));
      rr = ($urandom_range(0, 99) < 7);
      step(cv, ct, vd, vp, rr);
      chk_model($sformatf("rand%0d", i));
    end

    // Reset asserted right after the first quarter of a dollar refund.
    apply_reset();
    step(1'b1, 2'b11, 1'b0, 8'd0, 1'b0);
    chk_model("rst_seq load");
    step(1'b0, 2'b00, 1'b0, 8'd0, 1'b1);
    chk_model("rst_seq enter");
    idle_step();
    chk_all("rst_seq first_q", 75, 0, 0, 1, 2, 1);
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      idle_step();
      chk_all($sformatf("rst_seq after%0d", i), 0, 0, 0, 0, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
